// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-wide RAM port controller.
// Holds the controller FSM state encoding, the mem_len encodings with a helper that maps them to
// byte counts, and the pipeline stall-signal width used elsewhere in the codebase.
package mem_ctrl_pkg;

  localparam int unsigned StallSignalLen = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } mem_state_e;

  localparam logic [1:0] LenByte  = 2'd0;
  localparam logic [1:0] LenHalf  = 2'd1;
  localparam logic [1:0] LenWord  = 2'd2;
  localparam logic [1:0] LenWord3 = 2'd3;  // reserved encoding, behaves as a word

  // Number of byte transfers for a mem_len encoding.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LenByte: n = 3'd1;
      LenHalf: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the single byte-wide RAM port between instruction fetch (IF) and
// load/store (MEM). Each access is a run of consecutive byte transfers; words are assembled
// and split little-endian. Reads see a 1-cycle RAM latency.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_flush       fetch request (always 4 bytes), abort of fetch
//   if_done/if_inst               one-cycle completion pulse and fetched word
//   mem_req/mem_we/mem_addr/
//   mem_len/mem_wdata             load/store request
//   mem_done/mem_rdata            one-cycle completion pulse and zero-extended load data
//   ram_a/ram_wr/ram_dout/ram_din RAM byte port
//   busy                          high whenever the FSM is not idle (feeds stall logic)
//
// Build option: define MEM_CTRL_RR_EN for round-robin arbitration on simultaneous requests;
// otherwise MEM always wins.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        busy
);

  mem_state_e  state_q, state_d;
  logic [2:0]  k_q, k_d;        // byte counter; in READ it runs one past the last address
  logic [2:0]  n_q, n_d;        // byte count of the current access
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;  // read assembly; cleared at grant so unread bytes stay 0
  logic        is_if_q, is_if_d;

  logic        if_ok;
  logic        grant_if;
  logic        grant_mem;
  logic [1:0]  byte_idx;

`ifdef MEM_CTRL_RR_EN
  logic rr_if_q, rr_if_d;  // 1: IF wins the next tie
`endif

  assign if_ok    = if_req & ~if_flush;
  assign byte_idx = 2'(k_q - 3'd1);

  // Arbitration, only meaningful in IDLE.
  always_comb begin
`ifdef MEM_CTRL_RR_EN
    if (if_ok && mem_req) begin
      grant_if  = rr_if_q;
      grant_mem = ~rr_if_q;
    end else begin
      grant_if  = if_ok;
      grant_mem = mem_req;
    end
    rr_if_d = rr_if_q;
    if (state_q == StIdle) begin
      if (grant_mem) rr_if_d = 1'b1;
      else if (grant_if) rr_if_d = 1'b0;
    end
`else
    grant_mem = mem_req;
    grant_if  = if_ok & ~mem_req;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      is_if_q <= 1'b0;
`ifdef MEM_CTRL_RR_EN
      rr_if_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      is_if_q <= is_if_d;
`ifdef MEM_CTRL_RR_EN
      rr_if_q <= rr_if_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    is_if_d = is_if_q;
    unique case (state_q)
      StIdle: begin
        if (grant_mem) begin
          addr_d  = mem_addr;
          n_d     = len_bytes(mem_len);
          wdata_d = mem_wdata;
          is_if_d = 1'b0;
          k_d     = '0;
          data_d  = '0;
          state_d = mem_we ? StWrite : StRead;
        end else if (grant_if) begin
          addr_d  = if_addr;
          n_d     = 3'd4;
          is_if_d = 1'b1;
          k_d     = '0;
          data_d  = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (is_if_q && if_flush) begin
          state_d = StIdle;
        end else begin
          // Byte k-1 arrives while address k is presented.
          if (k_q != 3'd0) data_d[{byte_idx, 3'b000} +: 8] = ram_din;
          if (k_q == n_q) state_d = StDone;
          else k_d = k_q + 3'd1;
        end
      end
      StWrite: begin
        if (k_q == n_q - 3'd1) state_d = StDone;
        else k_d = k_q + 3'd1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy      = (state_q != StIdle);
    ram_wr    = (state_q == StWrite);
    ram_a     = '0;
    ram_dout  = '0;
    if ((state_q == StRead && k_q != n_q) || state_q == StWrite) begin
      ram_a = addr_q + {29'b0, k_q};
    end
    if (state_q == StWrite) ram_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
    if_done   = (state_q == StDone) & is_if_q & ~if_flush;
    mem_done  = (state_q == StDone) & ~is_if_q;
    if_inst   = data_q;
    mem_rdata = data_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl. A behavioural ROM with 1-cycle
// registered read latency answers RAM reads. Outputs are sampled and inputs driven on the
// falling clock edge; "cycle c" is counted from the cycle a request is sampled in IDLE.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        busy;

  int vectors;
  int miscompares;

  mem_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_inst   (if_inst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'h0000_0100: b = 8'h13;
      32'h0000_0101: b = 8'h00;
      32'h0000_0102: b = 8'h00;
      32'h0000_0103: b = 8'h00;
      32'h0000_0010: b = 8'h34;
      32'h0000_0011: b = 8'h12;
      32'hFFFF_FFFE: b = 8'hAA;
      32'hFFFF_FFFF: b = 8'hBB;
      32'h0000_0000: b = 8'hCC;
      32'h0000_0001: b = 8'hDD;
      default:       b = 8'hEE;
    endcase
    return b;
  endfunction

  always @(posedge clk) ram_din <= rom_byte(ram_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wexp;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_len   = '0;
    mem_wdata = '0;
    step();
    step();

    // Reset state.
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_dones", {30'b0, if_done, mem_done}, 32'd0);
    rst = 1'b0;
    step();

    // 4-byte fetch at 0x100.
    if_req  = 1'b1;
    if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) chk($sformatf("fetch_ram_a_c%0d", c), ram_a, 32'h100 + 32'(c - 1));
      chk($sformatf("fetch_busy_c%0d", c), {31'b0, busy}, 32'd1);
      chk($sformatf("fetch_ram_wr_c%0d", c), {31'b0, ram_wr}, 32'd0);
      chk($sformatf("fetch_if_done_c%0d", c), {31'b0, if_done}, (c == 6) ? 32'd1 : 32'd0);
    end
    chk("fetch_inst", if_inst, 32'h0000_0013);
    if_req = 1'b0;

    // Word store at 0x200.
    step();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_len   = 2'd2;
    mem_addr  = 32'h200;
    mem_wdata = 32'hDEAD_BEEF;
    wexp      = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("st_ram_wr_c%0d", c), {31'b0, ram_wr}, (c <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("st_mem_done_c%0d", c), {31'b0, mem_done}, (c == 5) ? 32'd1 : 32'd0);
      if (c <= 4) begin
        chk($sformatf("st_ram_a_c%0d", c), ram_a, 32'h200 + 32'(c - 1));
        chk($sformatf("st_ram_dout_c%0d", c), {24'b0, ram_dout}, {24'b0, wexp[7:0]});
        wexp = wexp >> 8;
      end
    end
    mem_req = 1'b0;
    mem_we  = 1'b0;

    // Simultaneous fetch and 2-byte load at 0x10; MEM was granted last.
    step();
    if_req   = 1'b1;
    if_addr  = 32'h100;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'd1;
    mem_addr = 32'h10;
`ifdef MEM_CTRL_RR_EN
    step();
    chk("rr_first_ram_a", ram_a, 32'h100);
    for (int c = 2; c <= 6; c++) step();
    chk("rr_if_done", {31'b0, if_done}, 32'd1);
    chk("rr_mem_done_low", {31'b0, mem_done}, 32'd0);
    chk("rr_inst", if_inst, 32'h0000_0013);
    if_req = 1'b0;
    step();
    step();
    chk("rr_second_ram_a", ram_a, 32'h10);
    for (int c = 9; c <= 11; c++) step();
    chk("rr_mem_done", {31'b0, mem_done}, 32'd1);
    chk("rr_rdata", mem_rdata, 32'h0000_1234);
    mem_req = 1'b0;
`else
    step();
    chk("pri_first_ram_a", ram_a, 32'h10);
    step();
    chk("pri_ram_a_c2", ram_a, 32'h11);
    step();
    step();
    chk("pri_mem_done", {31'b0, mem_done}, 32'd1);
    chk("pri_if_done_low", {31'b0, if_done}, 32'd0);
    chk("pri_rdata", mem_rdata, 32'h0000_1234);
    mem_req = 1'b0;
    step();
    step();
    chk("pri_second_ram_a", ram_a, 32'h100);
    for (int c = 7; c <= 11; c++) step();
    chk("pri_if_done", {31'b0, if_done}, 32'd1);
    chk("pri_inst", if_inst, 32'h0000_0013);
    if_req = 1'b0;
`endif

    // Fetch flushed in cycle 2 with a byte load pending.
    step();
    if_req  = 1'b1;
    if_addr = 32'h100;
    step();
    step();
    chk("fl_busy_c2", {31'b0, busy}, 32'd1);
    if_flush = 1'b1;
    if_req   = 1'b0;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'd0;
    mem_addr = 32'h10;
    step();
    chk("fl_idle_c3", {31'b0, busy}, 32'd0);
    chk("fl_if_done_c3", {31'b0, if_done}, 32'd0);
    if_flush = 1'b0;
    step();
    chk("fl_mem_ram_a_c4", ram_a, 32'h10);
    step();
    chk("fl_if_done_c5", {31'b0, if_done}, 32'd0);
    step();
    chk("fl_mem_done_c6", {31'b0, mem_done}, 32'd1);
    chk("fl_rdata", mem_rdata, 32'h0000_0034);
    mem_req = 1'b0;

    // Reset asserted in cycle 2 of a store.
    step();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_len   = 2'd2;
    mem_addr  = 32'h300;
    mem_wdata = 32'h1122_3344;
    step();
    chk("rs_ram_wr_c1", {31'b0, ram_wr}, 32'd1);
    step();
    chk("rs_ram_wr_c2", {31'b0, ram_wr}, 32'd1);
    rst     = 1'b1;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    step();
    chk("rs_ram_wr_c3", {31'b0, ram_wr}, 32'd0);
    chk("rs_busy_c3", {31'b0, busy}, 32'd0);
    chk("rs_ram_a_c3", ram_a, 32'd0);
    chk("rs_ram_dout_c3", {24'b0, ram_dout}, 32'd0);
    chk("rs_if_inst_c3", if_inst, 32'd0);
    chk("rs_mem_rdata_c3", mem_rdata, 32'd0);
    rst = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      chk($sformatf("rs_dones_c%0d", c), {30'b0, if_done, mem_done}, 32'd0);
      step();
    end

    // Word load wrapping past 0xFFFFFFFF.
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'd2;
    mem_addr = 32'hFFFF_FFFE;
    step();
    chk("wr_ram_a_c1", ram_a, 32'hFFFF_FFFE);
    step();
    chk("wr_ram_a_c2", ram_a, 32'hFFFF_FFFF);
    step();
    chk("wr_ram_a_c3", ram_a, 32'h0000_0000);
    step();
    chk("wr_ram_a_c4", ram_a, 32'h0000_0001);
    step();
    chk("wr_mem_done_c5", {31'b0, mem_done}, 32'd0);
    step();
    chk("wr_mem_done_c6", {31'b0, mem_done}, 32'd1);
    chk("wr_rdata", mem_rdata, 32'hDDCC_BBAA);
    mem_req = 1'b0;
    step();
    chk("wr_idle", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
